hb_tap_sequencer: RTL and testbench

Control and addressing front end for a symmetric decimating FIR built around the 16x16 two-read-port sample RAM.
- Write side: writes incoming samples into the RAM as a circular buffer.
- Read side: on every DECIM-th sample, issues a burst of symmetric address pairs (newest/oldest moving inward) plus a coefficient index.
- Issues MAC framing strobes aligned to the RAM's 1-cycle read latency.
- Sits between the input sample strobe and the pre-adder/MAC datapath.

---
 rtl/hb_tap_sequencer.sv | 156 +++++++++++++++
 tb/tb_hb_tap_sequencer.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hb_tap_sequencer.sv
// hb_tap_sequencer
//   Control and addressing front end for a symmetric decimating FIR that
//   uses a 16x16 sample RAM with one write port and two read ports.
//   Incoming samples are written into the RAM as a circular buffer. Every
//   DECIM-th sample starts a burst of NUM_PAIRS symmetric address pairs
//   (newest/oldest, moving inward) with a matching coefficient index. MAC
//   framing strobes trail the addresses by one cycle to line up with the
//   RAM's registered read data.
//
// Parameters
//   NUM_PAIRS  symmetric tap pairs per output (1..7), filter length 2*NUM_PAIRS
//   DECIM      input samples per output computation (1..16)
//
// Ports
//   clock       system clock, rising edge
//   reset       asynchronous active-low reset
//   strobe_in   one-cycle qualifier for data_in
//   data_in     input sample
//   write       RAM write enable
//   wr_addr     RAM write address
//   wr_data     RAM write data
//   rd_addr1    RAM read port 1 address (newer half of window)
//   rd_addr2    RAM read port 2 address (older half of window)
//   coeff_addr  coefficient index, aligned with rd_addr1/rd_addr2
//   pair_valid  RAM read data for a pair is valid this cycle
//   first_pair  with pair_valid: first pair of the burst (MAC loads)
//   last_pair   with pair_valid: final pair of the burst
//   strobe_out  one-cycle pulse after last_pair; MAC result complete
//   busy        burst in progress
//   overrun     sticky: a start request arrived while busy
module hb_tap_sequencer #(
  parameter int NUM_PAIRS = 4,
  parameter int DECIM     = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        strobe_in,
  input  logic [15:0] data_in,
  output logic        write,
  output logic [3:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic [3:0]  rd_addr1,
  output logic [3:0]  rd_addr2,
  output logic [2:0]  coeff_addr,
  output logic        pair_valid,
  output logic        first_pair,
  output logic        last_pair,
  output logic        strobe_out,
  output logic        busy,
  output logic        overrun
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  // Distance from the newest to the oldest sample of the window.
  localparam logic [3:0] SPAN       = 4'(2 * NUM_PAIRS - 1);
  localparam logic [2:0] K_LAST     = 3'(NUM_PAIRS - 1);
  localparam logic [3:0] PHASE_LAST = 4'(DECIM - 1);

  logic [3:0] wr_ptr;
  logic [3:0] phase;
  logic       start_req;
  logic [0:0] state;
  logic [2:0] k;
  logic [3:0] base;
  logic [2:0] k_next;
  logic [3:0] k_next_w;

  assign k_next   = k + 3'd1;
  assign k_next_w = {1'b0, k_next};
  assign busy     = (state == RUN);

  // Write path and decimation phase. The start request is registered so it
  // appears in the same cycle as the write; base is then the address being
  // written, and the first read follows the write edge.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      write     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      wr_ptr    <= '0;
      phase     <= '0;
      start_req <= 1'b0;
    end else begin
      write     <= strobe_in;
      start_req <= strobe_in && (phase == PHASE_LAST);
      if (strobe_in) begin
        wr_addr <= wr_ptr;
        wr_data <= data_in;
        wr_ptr  <= wr_ptr + 4'd1;
        phase   <= (phase == PHASE_LAST) ? 4'd0 : phase + 4'd1;
      end
    end
  end

  // Burst sequencer. Read addresses are registered and loaded one step
  // ahead, so they simply hold their last values once the burst ends.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      k          <= '0;
      base       <= '0;
      rd_addr1   <= '0;
      rd_addr2   <= '0;
      coeff_addr <= '0;
      overrun    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_req) begin
            state      <= RUN;
            k          <= '0;
            base       <= wr_addr;
            rd_addr1   <= wr_addr;
            rd_addr2   <= wr_addr - SPAN;
            coeff_addr <= '0;
          end
        end
        RUN: begin
          // A request during a burst is dropped; the burst is not disturbed.
          if (start_req) begin
            overrun <= 1'b1;
          end
          if (k == K_LAST) begin
            state <= IDLE;
          end else begin
            k          <= k_next;
            rd_addr1   <= base - k_next_w;
            rd_addr2   <= base - SPAN + k_next_w;
            coeff_addr <= k_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Framing trails the address issue by one cycle (RAM read latency).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pair_valid <= 1'b0;
      first_pair <= 1'b0;
      last_pair  <= 1'b0;
      strobe_out <= 1'b0;
    end else begin
      pair_valid <= (state == RUN);
      first_pair <= (state == RUN) && (k == 3'd0);
      last_pair  <= (state == RUN) && (k == K_LAST);
      strobe_out <= last_pair;
    end
  end

endmodule

// File: tb/tb_hb_tap_sequencer.sv
// tb_hb_tap_sequencer
//   Directed bench for hb_tap_sequencer. Three instances cover the
//   configurations of interest: (NUM_PAIRS=4, DECIM=2), (4, 1) and (1, 2).
//   Each instance feeds a small two-read-port RAM model so that pair data
//   can be checked against the samples the bench wrote.
module tb_hb_tap_sequencer;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        strobe_i  [3];
  logic [15:0] data_i    [3];
  logic        write_o   [3];
  logic [3:0]  wr_addr_o [3];
  logic [15:0] wr_data_o [3];
  logic [3:0]  rd1_o     [3];
  logic [3:0]  rd2_o     [3];
  logic [2:0]  coeff_o   [3];
  logic        pv_o      [3];
  logic        fp_o      [3];
  logic        lp_o      [3];
  logic        so_o      [3];
  logic        busy_o    [3];
  logic        ovr_o     [3];

  int n_checks = 0;
  int n_fail   = 0;

  // Bench-side record of what was written where, per instance.
  int          exp_ptr [3];
  logic [15:0] shadow  [3][16];

  hb_tap_sequencer #(.NUM_PAIRS(4), .DECIM(2)) dut_a (
    .clock(clock), .reset(reset), .strobe_in(strobe_i[0]), .data_in(data_i[0]),
    .write(write_o[0]), .wr_addr(wr_addr_o[0]), .wr_data(wr_data_o[0]),
    .rd_addr1(rd1_o[0]), .rd_addr2(rd2_o[0]), .coeff_addr(coeff_o[0]),
    .pair_valid(pv_o[0]), .first_pair(fp_o[0]), .last_pair(lp_o[0]),
    .strobe_out(so_o[0]), .busy(busy_o[0]), .overrun(ovr_o[0]));

  hb_tap_sequencer #(.NUM_PAIRS(4), .DECIM(1)) dut_b (
    .clock(clock), .reset(reset), .strobe_in(strobe_i[1]), .data_in(data_i[1]),
    .write(write_o[1]), .wr_addr(wr_addr_o[1]), .wr_data(wr_data_o[1]),
    .rd_addr1(rd1_o[1]), .rd_addr2(rd2_o[1]), .coeff_addr(coeff_o[1]),
    .pair_valid(pv_o[1]), .first_pair(fp_o[1]), .last_pair(lp_o[1]),
    .strobe_out(so_o[1]), .busy(busy_o[1]), .overrun(ovr_o[1]));

  hb_tap_sequencer #(.NUM_PAIRS(1), .DECIM(2)) dut_c (
    .clock(clock), .reset(reset), .strobe_in(strobe_i[2]), .data_in(data_i[2]),
    .write(write_o[2]), .wr_addr(wr_addr_o[2]), .wr_data(wr_data_o[2]),
    .rd_addr1(rd1_o[2]), .rd_addr2(rd2_o[2]), .coeff_addr(coeff_o[2]),
    .pair_valid(pv_o[2]), .first_pair(fp_o[2]), .last_pair(lp_o[2]),
    .strobe_out(so_o[2]), .busy(busy_o[2]), .overrun(ovr_o[2]));

  // Sample RAM model: synchronous write, registered reads on both ports.
  logic [15:0] mem [3][16];
  logic [15:0] q1  [3];
  logic [15:0] q2  [3];
  always @(posedge clock) begin
    for (int d = 0; d < 3; d++) begin
      if (write_o[d]) mem[d][wr_addr_o[d]] <= wr_data_o[d];
      q1[d] <= mem[d][rd1_o[d]];
      q2[d] <= mem[d][rd2_o[d]];
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [37:0] outs(input int d);
    return {write_o[d], wr_addr_o[d], wr_data_o[d], rd1_o[d], rd2_o[d], coeff_o[d],
            pv_o[d], fp_o[d], lp_o[d], so_o[d], busy_o[d], ovr_o[d]};
  endfunction

  // One strobe; on return the bench sits in the write cycle (T+1).
  task automatic strobe_once(input int d, input logic [15:0] v, input string tag);
    logic [20:0] e;
    strobe_i[d] = 1'b1;
    data_i[d]   = v;
    shadow[d][exp_ptr[d]] = v;
    tick();
    strobe_i[d] = 1'b0;
    e = {1'b1, 4'(exp_ptr[d]), v};
    n_checks++;
    if ({write_o[d], wr_addr_o[d], wr_data_o[d]} !== e) begin
      n_fail++;
      $display("FAIL %s write: got %h expected %h", tag,
               {write_o[d], wr_addr_o[d], wr_data_o[d]}, e);
    end
    exp_ptr[d] = (exp_ptr[d] + 1) % 16;
  endtask

  // Follows a burst from the write cycle (T+1) through strobe_out.
  // wr_at >= 0 injects one strobe during RUN cycle index wr_at.
  task automatic observe_burst(input int d, input logic [3:0] base, input int n,
                               input int wr_at, input string tag);
    logic [15:0] exp1 [7];
    logic [15:0] exp2 [7];
    logic [3:0]  span;
    logic [11:0] e_run;
    logic [34:0] e_pair;
    logic [8:0]  e_tail;
    int          wr_exp;
    wr_exp = 0;
    span = 4'(2 * n - 1);
    for (int k = 0; k < n; k++) begin
      exp1[k] = shadow[d][base - 4'(k)];
      exp2[k] = shadow[d][base - span + 4'(k)];
    end
    for (int i = 0; i <= n; i++) begin
      tick();
      if (wr_at >= 0 && i == wr_at + 1) begin
        strobe_i[d] = 1'b0;
        n_checks++;
        if ({write_o[d], wr_addr_o[d]} !== {1'b1, 4'(wr_exp)}) begin
          n_fail++;
          $display("FAIL %s write in run: got %h expected %h", tag,
                   {write_o[d], wr_addr_o[d]}, {1'b1, 4'(wr_exp)});
        end
      end
      n_checks++;
      if (i < n) begin
        e_run = {1'b1, base - 4'(i), base - span + 4'(i), 3'(i)};
        if ({busy_o[d], rd1_o[d], rd2_o[d], coeff_o[d]} !== e_run) begin
          n_fail++;
          $display("FAIL %s addr k=%0d: got %h expected %h", tag, i,
                   {busy_o[d], rd1_o[d], rd2_o[d], coeff_o[d]}, e_run);
        end
      end else if (busy_o[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL %s busy end: got %b expected 0", tag, busy_o[d]);
      end
      n_checks++;
      if (i == 0) begin
        if ({pv_o[d], fp_o[d], lp_o[d]} !== 3'b000) begin
          n_fail++;
          $display("FAIL %s early frame: got %b expected 000", tag,
                   {pv_o[d], fp_o[d], lp_o[d]});
        end
      end else begin
        e_pair = {1'b1, i == 1, i == n, exp1[i-1], exp2[i-1]};
        if ({pv_o[d], fp_o[d], lp_o[d], q1[d], q2[d]} !== e_pair) begin
          n_fail++;
          $display("FAIL %s pair %0d: got %h expected %h", tag, i - 1,
                   {pv_o[d], fp_o[d], lp_o[d], q1[d], q2[d]}, e_pair);
        end
      end
      if (i == wr_at) begin
        strobe_i[d] = 1'b1;
        data_i[d]   = 16'hC0DE;
        shadow[d][exp_ptr[d]] = 16'hC0DE;
        wr_exp = exp_ptr[d];
        exp_ptr[d] = (exp_ptr[d] + 1) % 16;
      end
    end
    tick();
    e_tail = {1'b1, 1'b0, base - 4'(n - 1), 3'(n - 1)};
    n_checks++;
    if ({so_o[d], pv_o[d], rd1_o[d], coeff_o[d]} !== e_tail) begin
      n_fail++;
      $display("FAIL %s strobe_out/hold: got %h expected %h", tag,
               {so_o[d], pv_o[d], rd1_o[d], coeff_o[d]}, e_tail);
    end
    tick();
    n_checks++;
    if (so_o[d] !== 1'b0) begin
      n_fail++;
      $display("FAIL %s strobe_out width: got %b expected 0", tag, so_o[d]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (outs(d) !== '0) begin
        n_fail++;
        $display("FAIL reset_async dut%0d: got %h expected 0", d, outs(d));
      end
    end
    tick();
    @(negedge clock);
    reset = 1'b1;
    tick();
    for (int d = 0; d < 3; d++) begin
      exp_ptr[d] = 0;
      n_checks++;
      if (outs(d) !== '0) begin
        n_fail++;
        $display("FAIL reset_idle dut%0d: got %h expected 0", d, outs(d));
      end
    end
  endtask

  task automatic test_basic();
    for (int s = 1; s <= 8; s++) begin
      strobe_once(0, 16'(s), "basic");
      if (s < 8) repeat (3) tick();
    end
    observe_burst(0, 4'd7, 4, -1, "basic");
    n_checks++;
    if (ovr_o[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL basic overrun: got %b expected 0", ovr_o[0]);
    end
  endtask

  task automatic test_wrap();
    int a;
    for (int s = 0; s < 20; s++) begin
      a = exp_ptr[0];
      strobe_once(0, 16'h0A00 + 16'(s), "wrap");
      if (a % 2 == 1) observe_burst(0, 4'(a), 4, -1, "wrap");
      else repeat (7) tick();
    end
  endtask

  task automatic test_write_during_run();
    strobe_once(0, 16'hB000, "wdr");
    repeat (7) tick();
    strobe_once(0, 16'hB001, "wdr");
    observe_burst(0, 4'd13, 4, 1, "wdr");
  endtask

  task automatic test_overrun();
    int          starts [3] = '{2, 7, 12};
    logic [3:0]  b;
    int          k;
    logic        e_busy;
    logic [11:0] e_run;
    logic        e_pv;
    logic [2:0]  e_frame;
    logic [31:0] e_q;
    logic        e_so;
    strobe_i[1] = 1'b1;
    data_i[1]   = 16'h0100;
    shadow[1][0] = 16'h0100;
    for (int c = 1; c < 20; c++) begin
      tick();
      if (c <= 11) begin
        strobe_i[1] = 1'b1;
        data_i[1]   = 16'h0100 + 16'(c);
        shadow[1][c] = data_i[1];
      end else begin
        strobe_i[1] = 1'b0;
      end
      e_busy = 1'b0; e_run = '0; e_pv = 1'b0; e_frame = '0; e_q = '0; e_so = 1'b0;
      for (int j = 0; j < 3; j++) begin
        b = 4'(starts[j] - 2);
        if (c >= starts[j] && c <= starts[j] + 3) begin
          k = c - starts[j];
          e_busy = 1'b1;
          e_run = {1'b1, b - 4'(k), b - 4'd7 + 4'(k), 3'(k)};
        end
        if (c - 1 >= starts[j] && c - 1 <= starts[j] + 3) begin
          k = c - 1 - starts[j];
          e_pv = 1'b1;
          e_frame = {1'b1, k == 0, k == 3};
          e_q = {shadow[1][b - 4'(k)], shadow[1][b - 4'd7 + 4'(k)]};
        end
        if (c == starts[j] + 5) e_so = 1'b1;
      end
      n_checks++;
      if (c <= 12) begin
        if ({write_o[1], wr_addr_o[1], wr_data_o[1]} !== {1'b1, 4'(c - 1), 16'h0100 + 16'(c - 1)}) begin
          n_fail++;
          $display("FAIL ovr write c=%0d: got %h", c, {write_o[1], wr_addr_o[1], wr_data_o[1]});
        end
      end else if (write_o[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL ovr write c=%0d: got %b expected 0", c, write_o[1]);
      end
      n_checks++;
      if (e_busy) begin
        if ({busy_o[1], rd1_o[1], rd2_o[1], coeff_o[1]} !== e_run) begin
          n_fail++;
          $display("FAIL ovr addr c=%0d: got %h expected %h", c,
                   {busy_o[1], rd1_o[1], rd2_o[1], coeff_o[1]}, e_run);
        end
      end else if (busy_o[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL ovr busy c=%0d: got 1 expected 0", c);
      end
      n_checks++;
      if ({pv_o[1], fp_o[1], lp_o[1], so_o[1]} !== {e_frame, e_so}) begin
        n_fail++;
        $display("FAIL ovr frame c=%0d: got %b expected %b", c,
                 {pv_o[1], fp_o[1], lp_o[1], so_o[1]}, {e_frame, e_so});
      end
      if (e_pv) begin
        n_checks++;
        if ({q1[1], q2[1]} !== e_q) begin
          n_fail++;
          $display("FAIL ovr data c=%0d: got %h expected %h", c, {q1[1], q2[1]}, e_q);
        end
      end
      n_checks++;
      if (ovr_o[1] !== (c >= 3)) begin
        n_fail++;
        $display("FAIL ovr flag c=%0d: got %b expected %b", c, ovr_o[1], c >= 3);
      end
    end
    exp_ptr[1] = 12;
    repeat (3) tick();
    n_checks++;
    if ({ovr_o[1], busy_o[1]} !== 2'b10) begin
      n_fail++;
      $display("FAIL ovr sticky: got %b expected 10", {ovr_o[1], busy_o[1]});
    end
  endtask

  task automatic test_single_pair();
    strobe_once(2, 16'h2000, "np1");
    repeat (3) tick();
    strobe_once(2, 16'h2001, "np1");
    observe_burst(2, 4'd1, 1, -1, "np1");
    n_checks++;
    if ({ovr_o[0], ovr_o[2]} !== 2'b00) begin
      n_fail++;
      $display("FAIL np1 overrun: got %b expected 00", {ovr_o[0], ovr_o[2]});
    end
  endtask

  task automatic test_reset_mid();
    strobe_once(0, 16'hD000, "rstmid");
    tick();
    tick();
    n_checks++;
    if ({busy_o[0], pv_o[0]} !== 2'b11) begin
      n_fail++;
      $display("FAIL rstmid precondition: got %b expected 11", {busy_o[0], pv_o[0]});
    end
    for (int d = 0; d < 3; d++) begin
      strobe_i[d] = 1'($urandom_range(0, 1));
      data_i[d]   = 16'($urandom);
    end
    #2 reset = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (outs(d) !== '0) begin
        n_fail++;
        $display("FAIL rstmid async dut%0d: got %h expected 0", d, outs(d));
      end
    end
    tick();
    for (int d = 0; d < 3; d++) begin
      strobe_i[d] = 1'b0;
      exp_ptr[d]  = 0;
    end
    @(negedge clock);
    reset = 1'b1;
    repeat (4) begin
      tick();
      n_checks++;
      if (outs(0) !== '0) begin
        n_fail++;
        $display("FAIL rstmid aftermath: got %h expected 0", outs(0));
      end
    end
    strobe_once(0, 16'hE000, "rstmid");
    strobe_once(1, 16'hE001, "rstmid");
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      strobe_i[d] = 1'b0;
      data_i[d]   = 16'h0000;
      exp_ptr[d]  = 0;
    end
    test_reset();
    test_basic();
    test_wrap();
    test_write_during_run();
    test_overrun();
    test_single_pair();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
